// File: rtl/io_map_pkg.sv
// Shared constants for the KEY/SW conditioning block: register offsets and
// default sizing of the conditioned inputs.
package io_map_pkg;

    // Default board configuration: KEY[3:1] and SW[9:0].
    localparam int unsigned NKEYS_DEF     = 3;
    localparam int unsigned NSW_DEF       = 10;
    localparam int unsigned EVT_W         = NKEYS_DEF + NSW_DEF;

    // 10 ms of stability at 25 MHz.
    localparam int unsigned DB_CYCLES_DEF = 250000;
    localparam int unsigned CNT_W_DEF     = 18;

    // Word offsets within the block's I/O window.
    localparam logic [1:0] REG_SW   = 2'd0;
    localparam logic [1:0] REG_KEY  = 2'd1;
    localparam logic [1:0] REG_EVT  = 2'd2;
    localparam logic [1:0] REG_MASK = 2'd3;

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input bit: 2-flop synchroniser, stability counter and
// debounced level, plus single-cycle pulses flagging the level change that
// lands on the next clock edge.
module debounce_bit
    import io_map_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    // Set for active-low pins so the conditioned level reads 1 = asserted.
    parameter bit          INVERT    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0]       sync_q;
    logic             lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             din;

    // Inverting ahead of the synchroniser keeps the flops' reset value equal
    // to "released", so a button does not look pressed right after reset.
    assign din = raw_i ^ INVERT;

    // Two-stage synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    // Count consecutive cycles the synced value differs from the level;
    // adopt it once it has differed for DB_CYCLES cycles in a row.
    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        if (sync_q[1] == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
            lvl_d = sync_q[1];
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Level and counter state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lvl_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    assign lvl_o  = lvl_q;
    assign rise_o = lvl_d & ~lvl_q;
    assign fall_o = ~lvl_d & lvl_q;

endmodule

// File: rtl/key_sw_conditioner.sv
// KEY/SW conditioning stage in front of the CPU I/O read path: debounced
// levels, sticky W1C event register, interrupt mask and read mux.
module key_sw_conditioner
    import io_map_pkg::*;
#(
    parameter int unsigned NKEYS     = NKEYS_DEF,
    parameter int unsigned NSW       = NSW_DEF,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] key_raw,
    input  logic [NSW-1:0]   sw_raw,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             irq
);

    localparam int unsigned EvtW = NKEYS + NSW;

    // Keys report presses only; switches report both edge directions.
    localparam logic [EvtW-1:0] FallEvtMask = {{NSW{1'b1}}, {NKEYS{1'b0}}};

    logic [EvtW-1:0] raw_all;
    logic [EvtW-1:0] lvl, rise, fall;
    logic [EvtW-1:0] evt_set, evt_clr;
    logic [EvtW-1:0] events_q, events_d;
    logic [EvtW-1:0] mask_q, mask_d;
    logic            wr_evt, wr_mask;
    logic            unused_wdata;

    assign raw_all = {sw_raw, key_raw};

    for (genvar i = 0; i < EvtW; i++) begin : g_db
        debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W),
            .INVERT    (i < NKEYS)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .raw_i  (raw_all[i]),
            .lvl_o  (lvl[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    assign wr_evt  = sel & we & (addr == REG_EVT);
    assign wr_mask = sel & we & (addr == REG_MASK);

    // Event/mask next state; a new edge beats a simultaneous W1C.
    always_comb begin
        evt_set  = rise | (fall & FallEvtMask);
        evt_clr  = wr_evt ? wdata[EvtW-1:0] : '0;
        events_d = (events_q & ~evt_clr) | evt_set;
        mask_d   = wr_mask ? wdata[EvtW-1:0] : mask_q;
    end

    // Sticky event and mask registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            events_q <= '0;
            mask_q   <= '0;
        end else begin
            events_q <= events_d;
            mask_q   <= mask_d;
        end
    end

    assign irq = |(events_q & mask_q);

    // Read mux; reads have no side effects and unused bits are zero.
    always_comb begin
        rdata = '0;
        if (sel) begin
            unique case (addr)
                REG_SW:   rdata = 32'(lvl[EvtW-1:NKEYS]);
                REG_KEY:  rdata = 32'(lvl[NKEYS-1:0]);
                REG_EVT:  rdata = 32'(events_q);
                REG_MASK: rdata = 32'(mask_q);
                default:  rdata = '0;
            endcase
        end
    end

    assign unused_wdata = ^wdata[31:EvtW];

endmodule
